// File: rtl/irq_controller.sv
// Interrupt controller: synchronises and edge-detects request lines, latches pending events,
// applies mask and fixed low-index-first priority, and tracks one non-nested ISR at a time.
module irq_controller #(
  parameter int         NUM_IRQ  = 4,
  parameter logic [7:0] VEC_BASE = 8'hF0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_in,
  input  logic               clr_overrun,
  input  logic               defer,
  input  logic               nopdf,
  output logic               interrupt,
  output logic [7:0]         isr_addr,
  output logic [1:0]         irq_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] overrun,
  output logic               spurious_ret
);

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] s1, s2, s3;
  logic [NUM_IRQ-1:0] rise, eligible, grant_mask;
  logic               grant;
  logic [1:0]         grant_idx;

  // s1/s2 resynchronise the asynchronous lines; s3 holds the previous level for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign eligible = pending & mask;

  // Scan downward so the lowest eligible index is the one left standing
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) grant_idx = 2'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      grant_mask[i] = grant && (grant_idx == 2'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible && !defer) begin
          grant     = 1'b1;
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (nopdf) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant edge: pulse, vector latch and pending clear; a same-cycle rise re-sets pending
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      interrupt    <= 1'b0;
      isr_addr     <= 8'h00;
      irq_id       <= 2'd0;
      pending      <= '0;
      mask         <= '0;
      overrun      <= '0;
      spurious_ret <= 1'b0;
    end else begin
      state     <= state_nxt;
      interrupt <= grant;
      if (grant) begin
        isr_addr <= VEC_BASE + {4'b0000, grant_idx, 2'b00};
        irq_id   <= grant_idx;
      end
      pending <= (pending & ~grant_mask) | rise;
      if (mask_we) mask <= mask_in;
      overrun      <= (clr_overrun ? '0 : overrun) | (rise & pending);
      spurious_ret <= spurious_ret | (nopdf && (state == IDLE));
    end
  end

  assign in_service = (state == SERVICE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller with hand-computed expectations.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       clr_overrun;
  logic       defer;
  logic       nopdf;
  logic       interrupt;
  logic [7:0] isr_addr;
  logic [1:0] irq_id;
  logic       in_service;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [3:0] overrun;
  logic       spurious_ret;

  int n_tests = 0;
  int n_fail  = 0;

  irq_controller #(.NUM_IRQ(4), .VEC_BASE(8'hF0)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .clr_overrun(clr_overrun), .defer(defer), .nopdf(nopdf), .interrupt(interrupt),
    .isr_addr(isr_addr), .irq_id(irq_id), .in_service(in_service), .pending(pending),
    .mask(mask), .overrun(overrun), .spurious_ret(spurious_ret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we = 1'b1;
    mask_in = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic ret();
    nopdf = 1'b1;
    tick();
    nopdf = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_int"}, interrupt, 0);
    check({tag, "_insvc"}, in_service, 0);
    check({tag, "_addr"}, isr_addr, 0);
    check({tag, "_id"}, irq_id, 0);
    check({tag, "_pend"}, pending, 0);
    check({tag, "_mask"}, mask, 0);
    check({tag, "_ovr"}, overrun, 0);
    check({tag, "_spur"}, spurious_ret, 0);
  endtask

  initial begin
    reset_n = 1'b0; irq = '0; mask_we = 1'b0; mask_in = '0;
    clr_overrun = 1'b0; defer = 1'b0; nopdf = 1'b0;
    tick(2);
    check_all_zero("rst");
    reset_n = 1'b1;

    // Single event on line 2
    write_mask(4'hF);
    check("t1_mask", mask, 4'hF);
    irq[2] = 1'b1;
    tick(3);
    check("t1_pend_e2", pending, 4'b0100);
    check("t1_noint_e2", interrupt, 0);
    irq[2] = 1'b0;
    tick();
    check("t1_int", interrupt, 1);
    check("t1_addr", isr_addr, 8'hF8);
    check("t1_id", irq_id, 2);
    check("t1_insvc", in_service, 1);
    check("t1_pend_clr", pending, 0);
    tick();
    check("t1_int_1cyc", interrupt, 0);
    check("t1_insvc_hold", in_service, 1);
    tick(3);
    ret();
    check("t1_insvc_off", in_service, 0);
    check("t1_addr_hold", isr_addr, 8'hF8);
    check("t1_spur", spurious_ret, 0);

    // Priority and back-to-back
    irq[3] = 1'b1; irq[1] = 1'b1;
    tick(3);
    check("t2_pend", pending, 4'b1010);
    irq[3] = 1'b0; irq[1] = 1'b0;
    tick();
    check("t2_int1", interrupt, 1);
    check("t2_addr1", isr_addr, 8'hF4);
    check("t2_id1", irq_id, 1);
    check("t2_pend1", pending, 4'b1000);
    tick(2);
    ret();
    check("t2_ret_int", interrupt, 0);
    check("t2_ret_insvc", in_service, 0);
    tick();
    check("t2_int2", interrupt, 1);
    check("t2_addr2", isr_addr, 8'hFC);
    check("t2_id2", irq_id, 3);
    check("t2_pend2", pending, 0);
    tick();
    ret();

    // Mask gating
    write_mask(4'b0001);
    irq[1] = 1'b1;
    tick(3);
    check("t3_pend", pending, 4'b0010);
    tick();
    check("t3_masked_noint", interrupt, 0);
    irq[1] = 1'b0;
    write_mask(4'b0011);
    check("t3_write_edge_noint", interrupt, 0);
    tick();
    check("t3_int", interrupt, 1);
    check("t3_addr", isr_addr, 8'hF4);
    tick();
    ret();

    // Overrun on a masked line, then clear
    write_mask(4'b1110);
    irq[0] = 1'b1;
    tick(3);
    check("t4_pend0", pending, 4'b0001);
    irq[0] = 1'b0;
    tick(3);
    irq[0] = 1'b1;
    tick(3);
    check("t4_ovr", overrun, 4'b0001);
    check("t4_noint", interrupt, 0);
    irq[0] = 1'b0;
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("t4_ovr_clr", overrun, 0);
    check("t4_pend_kept", pending, 4'b0001);

    // Defer held for 6 edges
    defer = 1'b1;
    write_mask(4'hF);
    check("t4_defer_e1", interrupt, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_defer_hold", interrupt, 0);
    end
    defer = 1'b0;
    tick();
    check("t4_defer_int", interrupt, 1);
    check("t4_defer_addr", isr_addr, 8'hF0);
    check("t4_defer_id", irq_id, 0);
    tick();
    ret();

    // Spurious return in IDLE
    ret();
    check("t5_spur", spurious_ret, 1);
    check("t5_spur_idle", in_service, 0);
    check("t5_spur_noint", interrupt, 0);

    // No nesting
    irq[3] = 1'b1;
    tick(3);
    irq[3] = 1'b0;
    tick();
    check("t5_int3", interrupt, 1);
    check("t5_addr3", isr_addr, 8'hFC);
    irq[2] = 1'b1;
    tick(4);
    irq[2] = 1'b0;
    check("t5_nest_noint", interrupt, 0);
    check("t5_nest_pend", pending, 4'b0100);
    check("t5_nest_insvc", in_service, 1);
    check("t5_nest_addr", isr_addr, 8'hFC);
    ret();
    check("t5_ret_insvc", in_service, 0);
    check("t5_ret_noint", interrupt, 0);
    tick();
    check("t5_int2", interrupt, 1);
    check("t5_addr2", isr_addr, 8'hF8);
    check("t5_pend_clr", pending, 0);

    // Async reset mid-service with line 1 pending
    irq[1] = 1'b1;
    tick(3);
    irq[1] = 1'b0;
    check("t6_pre_pend", pending, 4'b0010);
    check("t6_pre_insvc", in_service, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    reset_n = 1'b1;
    tick(6);
    check("t6_post_noint", interrupt, 0);
    check("t6_post_pend", pending, 0);
    irq[0] = 1'b1;
    tick(4);
    irq[0] = 1'b0;
    check("t6_new_pend", pending, 4'b0001);
    check("t6_new_noint", interrupt, 0);
    write_mask(4'hF);
    tick();
    check("t6_int", interrupt, 1);
    check("t6_addr", isr_addr, 8'hF0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
